// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle for one side of a pipeline stage.
// master drives valid and data, slave drives ready.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, stall (keep) and flush.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/flush performance counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  pipe_stage_reg_if.slave         up_if,
  pipe_stage_reg_if.master        dn_if,
  input  logic                    i_flush,
  input  logic                    i_keep,
  output logic [1:0]              o_occupancy,
  output logic [31:0]             o_stall_cnt,
  output logic [31:0]             o_flush_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              valid_w;
  logic              ready_w;
  logic              acc;
  logic              drn;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign acc = up_if.valid & ready_w & ~i_flush;
  assign drn = valid_w & dn_if.ready & ~i_keep;

  // Next-state and payload steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = StEmpty;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_d = StOne;
            main_d  = up_if.data;
          end
        end
        StOne: begin
          if (acc && drn) begin
            main_d = up_if.data;
          end else if (acc) begin
            state_d = StTwo;
            skid_d  = up_if.data;
          end else if (drn) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (drn) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Outputs depend on registered state only (plus reset gating ready).
  always_comb begin
    valid_w     = 1'b0;
    ready_w     = 1'b0;
    o_occupancy = 2'd0;
    unique case (state_q)
      StEmpty: begin
        ready_w     = ~reset;
        o_occupancy = 2'd0;
      end
      StOne: begin
        valid_w     = 1'b1;
        ready_w     = ~reset;
        o_occupancy = 2'd1;
      end
      StTwo: begin
        valid_w     = 1'b1;
        o_occupancy = 2'd2;
      end
      default: begin
        valid_w     = 1'b0;
        ready_w     = 1'b0;
        o_occupancy = 2'd0;
      end
    endcase
  end

  assign up_if.ready = ready_w;
  assign dn_if.valid = valid_w;
  assign dn_if.data  = main_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid_w && !drn && !i_flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (i_flush && (valid_w || up_if.valid) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers with one generic block.
- Carries an arbitrary-width payload with valid/ready handshake on both sides.
- Adds a 2-entry skid buffer, so a downstream stall never drops or duplicates a beat.
- Hazard-unit stall (keep) and flush inputs are folded into the handshake; flush inserts a bubble.

Parameters:
DATA_W, 32, payload width in bits (packed control, PC, operands, register IDs); legal range 1 to 1024.
BUBBLE_VAL, 0, payload value loaded into both entries on flush and reset; width DATA_W, zero-extended.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-high reset
i_valid  in  1  upstream beat present
o_ready  out  1  stage can accept a beat this cycle
i_data  in  DATA_W  upstream payload
i_flush  in  1  synchronous flush: discard all held beats and any incoming beat
i_keep  in  1  hazard stall: hold the output beat, block drain
o_valid  out  1  output beat present
i_ready  in  1  downstream accepts
o_data  out  DATA_W  output payload (main entry)
o_occupancy  out  2  held beats, 0..2
o_stall_cnt  out  32  perf counter (see Optional Feature)
o_flush_cnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Storage: main entry drives o_data; skid entry holds overflow.
- State machine: EMPTY (0 beats), ONE (main valid), TWO (main and skid valid).
- o_valid = (state != EMPTY).
- o_occupancy encodes the state as 0, 1 or 2.
- o_ready = (state != TWO) & ~reset. It depends only on registered state, with no combinational path from i_ready or i_keep.
- acc = i_valid & o_ready & ~i_flush.
- drn = o_valid & i_ready & ~i_keep.
- Priority order: reset, then flush, then normal transitions.
- Flush (i_flush=1 at an edge): next state EMPTY; main and skid <= BUBBLE_VAL; the incoming beat is dropped. Flush overrides i_keep and acc.
- EMPTY:
  - acc -> ONE, main <= i_data.
  - otherwise stay EMPTY.
- ONE:
  - acc & drn -> ONE, main <= i_data.
  - acc & ~drn -> TWO, skid <= i_data.
  - ~acc & drn -> EMPTY.
  - neither -> hold.
- TWO (acc impossible because o_ready=0):
  - drn -> ONE, main <= skid.
  - otherwise hold.
- Latency: a beat accepted at edge k appears on o_data after edge k (1 cycle). Throughput is 1 beat/cycle when never stalled.
- Strict FIFO order; no beat is duplicated or lost except by flush.
- i_keep blocks only drain; accept continues until TWO is reached, then o_ready deasserts.
- Payload is not modified; o_data holds its last value while EMPTY (BUBBLE_VAL after flush or reset).
- Reset (asynchronous, any state, mid-transfer included):
  - state EMPTY, o_valid=0, o_ready=0 while asserted then 1, o_occupancy=0.
  - main/skid/o_data = BUBBLE_VAL.
  - both counters = 0.
- No X propagation: the skid entry is never observable unless state is TWO.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - o_stall_cnt increments each cycle with o_valid & ~drn & ~i_flush.
  - o_flush_cnt increments each cycle with i_flush & (o_valid | i_valid).
  - Both saturate at 32'hFFFF_FFFF; both are cleared only by reset.
- Not defined: both ports tied to 0, with no counter flops synthesised. Handshake behaviour is identical in both builds.

Test Plan:
- Reset release, then beats 0x11, 0x22, 0x33 on consecutive cycles, i_ready=1 -> o_data shows 0x11, 0x22, 0x33 one cycle after each accept; o_occupancy stays at or below 1; o_ready=1 throughout.
- i_ready=0, push 0xA1, 0xA2, 0xA3 -> after two accepts o_occupancy=2 and o_ready=0; 0xA3 is held upstream. Raise i_ready -> output 0xA1, 0xA2, 0xA3 in order with no gaps.
- State TWO (0xB1, 0xB2), i_keep=1 with i_ready=1 for 3 cycles -> o_data=0xB1 stable, occupancy 2. Drop i_keep -> 0xB1 then 0xB2 drain.
- State ONE, i_flush=1 together with i_valid=1 (0xC5) and i_keep=1 -> next cycle o_valid=0, o_data=BUBBLE_VAL, occupancy 0; 0xC5 never appears on the output.
- Assert reset asynchronously mid-clock in state TWO -> o_valid, o_ready and o_occupancy drop immediately (before the next edge); o_data=BUBBLE_VAL. After release the first accepted beat is output correctly.
- With PIPE_STAGE_PERF_EN: 5 cycles of valid with i_ready=0, then 2 flush cycles with data held -> o_stall_cnt=5, o_flush_cnt=2. Without the macro -> both read 0.
